// File: rtl/aud_dac_tx.sv
// Serial audio transmitter: streams memory words LSB first, holding each bit
// for BIT_PERIOD clocks, prefetching the next word so words play back to back.
module aud_dac_tx #(
    parameter int WORD_W     = 256,
    parameter int ADDR_W     = 7,
    parameter int LAST_ADDR  = 122,
    parameter int BIT_PERIOD = 800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [WORD_W-1:0] mem_q,
    output logic              AUD_DACDAT,
    output logic              bit_strobe,
    output logic              busy,
    output logic              done
);

    localparam int TMR_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;

    state_t              state;
    logic [TMR_W-1:0]    bit_tmr;
    logic [7:0]          bit_idx;
    logic [ADDR_W-1:0]   word_cnt;
    logic [WORD_W-1:0]   shift_reg;
    logic [WORD_W-1:0]   next_buf;
    logic                rd_d;

    logic tmr_last;
    logic bit_last;
    logic word_last;

    assign tmr_last  = (bit_tmr == TMR_W'(BIT_PERIOD - 1));
    assign bit_last  = (bit_idx == 8'(WORD_W - 1));
    assign word_last = (word_cnt == ADDR_W'(LAST_ADDR));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_tmr    <= '0;
            bit_idx    <= '0;
            word_cnt   <= '0;
            shift_reg  <= '0;
            next_buf   <= '0;
            rd_d       <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            AUD_DACDAT <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (state != IDLE && abort) begin
            state      <= IDLE;
            bit_tmr    <= '0;
            bit_idx    <= '0;
            word_cnt   <= '0;
            rd_d       <= 1'b0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            AUD_DACDAT <= 1'b0;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            bit_strobe <= 1'b0;
            done       <= 1'b0;
            // One-cycle-delayed read strobe marks the cycle mem_q carries prefetched data.
            rd_d       <= mem_rd;
            case (state)
                IDLE: begin
                    AUD_DACDAT <= 1'b0;
                    mem_addr   <= '0;
                    word_cnt   <= '0;
                    bit_tmr    <= '0;
                    bit_idx    <= '0;
                    if (start && !abort) begin
                        state    <= FETCH;
                        mem_rd   <= 1'b1;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    state      <= SHIFT;
                    shift_reg  <= mem_q;
                    AUD_DACDAT <= mem_q[0];
                    bit_strobe <= 1'b1;
                    bit_tmr    <= '0;
                    bit_idx    <= '0;
                    if (LAST_ADDR > 0) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= ADDR_W'(1);
                    end
                end
                SHIFT: begin
                    if (rd_d) begin
                        next_buf <= mem_q;
                    end
                    if (!tmr_last) begin
                        bit_tmr <= bit_tmr + TMR_W'(1);
                    end else begin
                        bit_tmr <= '0;
                        if (!bit_last) begin
                            bit_idx    <= bit_idx + 8'd1;
                            shift_reg  <= {1'b0, shift_reg[WORD_W-1:1]};
                            AUD_DACDAT <= shift_reg[1];
                            bit_strobe <= 1'b1;
                        end else if (word_last) begin
                            state      <= DONE;
                            AUD_DACDAT <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            // Swap in the prefetched word so its bit 0 follows without a gap.
                            bit_idx    <= '0;
                            word_cnt   <= word_cnt + ADDR_W'(1);
                            shift_reg  <= next_buf;
                            AUD_DACDAT <= next_buf[0];
                            bit_strobe <= 1'b1;
                            if (word_cnt + ADDR_W'(1) != ADDR_W'(LAST_ADDR)) begin
                                mem_rd   <= 1'b1;
                                mem_addr <= word_cnt + ADDR_W'(2);
                            end
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    AUD_DACDAT <= 1'b0;
                    mem_addr   <= '0;
                    word_cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aud_dac_tx.sv
// Directed bench for aud_dac_tx with 8-bit words, three words, four clocks per bit.
module tb_aud_dac_tx;

    localparam int WORD_W     = 8;
    localparam int ADDR_W     = 7;
    localparam int LAST_ADDR  = 2;
    localparam int BIT_PERIOD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [WORD_W-1:0] mem_q = '0;
    logic              AUD_DACDAT;
    logic              bit_strobe;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [7:0] words [3] = '{8'hA5, 8'h3C, 8'hFF};

    aud_dac_tx #(
        .WORD_W(WORD_W), .ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR), .BIT_PERIOD(BIT_PERIOD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
        .AUD_DACDAT(AUD_DACDAT), .bit_strobe(bit_strobe), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous sample memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) begin
            case (mem_addr)
                7'd0:    mem_q <= 8'hA5;
                7'd1:    mem_q <= 8'h3C;
                7'd2:    mem_q <= 8'hFF;
                default: mem_q <= 8'h00;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".dac"},    32'(AUD_DACDAT), 32'd0);
        check({tag, ".rd"},     32'(mem_rd),     32'd0);
        check({tag, ".strobe"}, 32'(bit_strobe), 32'd0);
        check({tag, ".busy"},   32'(busy),       32'd0);
        check({tag, ".done"},   32'(done),       32'd0);
        check({tag, ".addr"},   32'(mem_addr),   32'd0);
    endtask

    // Starts a playback and checks it cycle by cycle; optionally re-pulses start,
    // aborts, or resets at stream cycle restart_at / abort_at / rst_at.
    task automatic play(input string tag, input int restart_at, input int abort_at, input int rst_at);
        int         rd_cnt;
        logic [7:0] w;
        bit         stopped;
        stopped = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".fetch_rd"},   32'(mem_rd),   32'd1);
        check({tag, ".fetch_addr"}, 32'(mem_addr), 32'd0);
        check({tag, ".fetch_busy"}, 32'(busy),     32'd1);
        rd_cnt = 1;
        tick();
        check({tag, ".wait_rd"}, 32'(mem_rd), 32'd0);
        tick();
        for (int t = 0; t < 96; t++) begin
            w = words[t / 32];
            check($sformatf("%s.dac[%0d]", tag, t),    32'(AUD_DACDAT), 32'(w[(t / 4) % 8]));
            check($sformatf("%s.strobe[%0d]", tag, t), 32'(bit_strobe), 32'(t % 4 == 0));
            check($sformatf("%s.done[%0d]", tag, t),   32'(done),       32'd0);
            check($sformatf("%s.busy[%0d]", tag, t),   32'(busy),       32'd1);
            if (t == 0 || t == 32)
                check($sformatf("%s.pf_addr[%0d]", tag, t), 32'(mem_addr), 32'(t / 32 + 1));
            if (mem_rd) rd_cnt++;
            if (t == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_quiet({tag, ".abort"});
                tick();
                check_quiet({tag, ".abort2"});
                stopped = 1'b1;
                break;
            end
            if (t == rst_at) begin
                #2 rst = 1'b0;
                #1;
                check_quiet({tag, ".rst_async"});
                tick();
                check_quiet({tag, ".rst_held"});
                rst = 1'b1;
                tick();
                check_quiet({tag, ".rst_rel"});
                stopped = 1'b1;
                break;
            end
            start = (t == restart_at);
            tick();
        end
        start = 1'b0;
        if (!stopped) begin
            check({tag, ".done_pulse"}, 32'(done),       32'd1);
            check({tag, ".done_dac"},   32'(AUD_DACDAT), 32'd0);
            check({tag, ".done_busy"},  32'(busy),       32'd1);
            tick();
            check_quiet({tag, ".after_done"});
            check({tag, ".rd_count"}, 32'(rd_cnt), 32'd3);
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        check_quiet("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check_quiet("post_reset_idle");

        play("basic", -1, -1, -1);
        tick();
        play("restart_ignored", 40, -1, -1);
        tick();
        play("abort", -1, 44, -1);
        play("abort_replay", -1, -1, -1);
        tick();
        play("mid_rst", -1, -1, 50);
        play("rst_replay", -1, -1, -1);

        start = 1'b1;
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("start_abort.rd[%0d]", i),   32'(mem_rd), 32'd0);
            check($sformatf("start_abort.busy[%0d]", i), 32'(busy),   32'd0);
        end
        start = 1'b0;
        abort = 1'b0;
        tick();
        check_quiet("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
